// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath muxes, enables and the ALU operation code.
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] funct_q, funct_d;
    logic       funct_legal;

    always_comb begin
        funct_legal = (funct == 3'b000) || (funct == 3'b001) || (funct == 3'b010) ||
                      (funct == 3'b110) || (funct == 3'b111);
    end

    // funct is captured in DECODE so EXEC does not depend on the IR staying stable
    always_comb begin
        funct_d = (state_q == S_DECODE) ? funct : funct_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    4'b0000: state_d = funct_legal ? S_EXEC : S_ILLEGAL;
                    4'b0001,
                    4'b0010: state_d = S_MEMADR;
                    4'b0011: state_d = S_BRANCH;
                    4'b0100: state_d = S_ADDIEX;
                    4'b0101: state_d = S_JUMP;
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (opcode == 4'b0001) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b010;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                mem_req = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_q;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB:  reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   alu_control = 3'b000;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: builds expected per-cycle traces instruction by instruction
// and compares a halting and a non-halting controller against them.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset, zero, mem_ready;
    logic [3:0] opcode;
    logic [2:0] funct;

    logic [2:0] alu_control;
    logic       alu_src_a, pc_en, iord, mem_req, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] state;

    logic [2:0] nh_alu_control;
    logic       nh_alu_src_a, nh_pc_en, nh_iord, nh_mem_req, nh_mem_write, nh_ir_write;
    logic       nh_reg_write, nh_reg_dst, nh_mem_to_reg, nh_illegal;
    logic [1:0] nh_alu_src_b, nh_pc_src;
    logic [3:0] nh_state;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .iord(iord),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(nh_alu_control), .alu_src_a(nh_alu_src_a),
        .alu_src_b(nh_alu_src_b), .pc_src(nh_pc_src), .pc_en(nh_pc_en), .iord(nh_iord),
        .mem_req(nh_mem_req), .mem_write(nh_mem_write), .ir_write(nh_ir_write),
        .reg_write(nh_reg_write), .reg_dst(nh_reg_dst), .mem_to_reg(nh_mem_to_reg),
        .illegal(nh_illegal), .state(nh_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] alu;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       pc_en, iord, req, wr, irw, rw, rdst, m2r, ill;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic [3:0] nh_st;
        logic       rst, mr, z;
        logic [3:0] op;
        logic [2:0] fn;
        outs_t      o;
    } step_t;

    outs_t       got_outs;
    step_t       trace[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [3:0]  cur_op;
    logic [2:0]  cur_fn;

    assign got_outs = {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_req,
                       mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t idle();
        outs_t o = '0;
        o.alu = 3'b010;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // care=1 marks cycles where opcode/funct are sampled; elsewhere they are scrambled
    task automatic push(input logic [3:0] st, input logic mr, input logic z,
                        input logic care, input outs_t o);
        step_t s;
        s.st    = st;
        s.nh_st = st;
        s.rst   = 1'b0;
        s.mr    = mr;
        s.z     = z;
        s.op    = care ? cur_op : 4'($urandom);
        s.fn    = care ? cur_fn : 3'($urandom);
        s.o     = o;
        trace.push_back(s);
    endtask

    task automatic do_fetch(input int unsigned waits);
        outs_t o = idle();
        o.req = 1'b1;
        o.b   = 2'b01;
        for (int unsigned i = 0; i < waits; i++) push(4'd0, 1'b0, rbit(), 1'b0, o);
        o.irw   = 1'b1;
        o.pc_en = 1'b1;
        push(4'd0, 1'b1, rbit(), 1'b0, o);
    endtask

    task automatic do_mem(input logic [3:0] st, input logic wr, input int unsigned waits);
        outs_t o = idle();
        o.iord = 1'b1;
        o.req  = 1'b1;
        o.wr   = wr;
        for (int unsigned i = 0; i < waits; i++) push(st, 1'b0, rbit(), 1'b0, o);
        push(st, 1'b1, rbit(), 1'b0, o);
    endtask

    task automatic do_illegal();
        outs_t o = idle();
        o.ill = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            push(4'd12, 1'b0, rbit(), 1'b0, o);
            trace[$].nh_st = (i == 0) ? 4'd12 : 4'd0;
        end
        push(4'd12, 1'b0, rbit(), 1'b0, o);
        trace[$].nh_st = 4'd0;
        trace[$].rst   = 1'b1;
    endtask

    function automatic logic funct_ok(input logic [2:0] fn);
        return fn == 3'd0 || fn == 3'd1 || fn == 3'd2 || fn == 3'd6 || fn == 3'd7;
    endfunction

    // abort_memwr: reset lands in the first MEMWR cycle while memory is still busy
    task automatic build_instr(input logic [3:0] op, input logic [2:0] fn,
                               input int unsigned wf, input int unsigned wm,
                               input logic bz, input logic abort_memwr);
        outs_t o;
        cur_op = op;
        cur_fn = fn;
        do_fetch(wf);
        o = idle(); o.b = 2'b11;
        push(4'd1, rbit(), rbit(), 1'b1, o);
        if (op == 4'd1 || op == 4'd2) begin
            o = idle(); o.a = 1'b1; o.b = 2'b10;
            push(4'd2, rbit(), rbit(), 1'b1, o);
            if (op == 4'd1) begin
                do_mem(4'd3, 1'b0, wm);
                o = idle(); o.rw = 1'b1; o.m2r = 1'b1;
                push(4'd4, rbit(), rbit(), 1'b0, o);
            end else if (abort_memwr) begin
                o = idle(); o.iord = 1'b1; o.req = 1'b1; o.wr = 1'b1;
                push(4'd5, 1'b0, rbit(), 1'b0, o);
                trace[$].rst = 1'b1;
            end else begin
                do_mem(4'd5, 1'b1, wm);
            end
        end else if (op == 4'd0 && funct_ok(fn)) begin
            o = idle(); o.a = 1'b1; o.alu = fn;
            push(4'd6, rbit(), rbit(), 1'b0, o);
            o = idle(); o.rw = 1'b1; o.rdst = 1'b1;
            push(4'd7, rbit(), rbit(), 1'b0, o);
        end else if (op == 4'd3) begin
            o = idle(); o.a = 1'b1; o.alu = 3'b110; o.pcs = 2'b01; o.pc_en = bz;
            push(4'd8, rbit(), bz, 1'b0, o);
        end else if (op == 4'd4) begin
            o = idle(); o.a = 1'b1; o.b = 2'b10;
            push(4'd9, rbit(), rbit(), 1'b0, o);
            o = idle(); o.rw = 1'b1;
            push(4'd10, rbit(), rbit(), 1'b0, o);
        end else if (op == 4'd5) begin
            o = idle(); o.pcs = 2'b10; o.pc_en = 1'b1;
            push(4'd11, rbit(), rbit(), 1'b0, o);
        end else begin
            do_illegal();
        end
    endtask

    task automatic run_trace();
        step_t s;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            @(negedge clock);
            reset     = s.rst;
            mem_ready = s.mr;
            zero      = s.z;
            opcode    = s.op;
            funct     = s.fn;
            #1;
            check_eq($sformatf("state(exp %0d)", s.st), 32'(state), 32'(s.st));
            check_eq($sformatf("outs(state %0d)", s.st), 32'(got_outs), 32'(s.o));
            check_eq("nh_state", 32'(nh_state), 32'(s.nh_st));
            check_eq("nh_illegal", 32'(nh_illegal), 32'(s.nh_st == 4'd12));
        end
    endtask

    initial begin
        logic [3:0] op;
        logic [2:0] fn;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        @(posedge clock);

        build_instr(4'd0, 3'b110, 0, 0, 1'b0, 1'b0); run_trace();   // R-type SUB
        build_instr(4'd1, 3'b000, 0, 2, 1'b0, 1'b0); run_trace();   // LW, 2 wait cycles
        build_instr(4'd3, 3'b000, 0, 0, 1'b1, 1'b0); run_trace();   // BEQ taken
        build_instr(4'd3, 3'b000, 0, 0, 1'b0, 1'b0); run_trace();   // BEQ not taken
        build_instr(4'd10, 3'b000, 0, 0, 1'b0, 1'b0); run_trace();  // illegal opcode
        build_instr(4'd0, 3'b011, 0, 0, 1'b0, 1'b0); run_trace();   // illegal funct
        build_instr(4'd2, 3'b000, 0, 0, 1'b0, 1'b1); run_trace();   // reset in MEMWR
        build_instr(4'd5, 3'b000, 3, 0, 1'b0, 1'b0); run_trace();   // stalled fetch then J
        cur_op = 4'd5;
        do_fetch(0);
        trace[$].rst = 1'b1;                                        // reset beats mem_ready
        build_instr(4'd4, 3'b000, 0, 0, 1'b0, 1'b0); run_trace();   // ADDI
        build_instr(4'd2, 3'b000, 1, 1, 1'b0, 1'b0); run_trace();   // SW with waits

        for (int unsigned k = 0; k < 120; k++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            fn = 3'($urandom);
            build_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), 1'b0);
            run_trace();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
